// File: rtl/pong_pkg.sv
// Shared constants for the Pong sequencer: FSM encoding, status-word layout,
// screen geometry and the bar clamp helper.
package pong_pkg;
  localparam logic [2:0] ST_MENU     = 3'd0;
  localparam logic [2:0] ST_SERVE    = 3'd1;
  localparam logic [2:0] ST_PLAY     = 3'd2;
  localparam logic [2:0] ST_POINT    = 3'd3;
  localparam logic [2:0] ST_GAMEOVER = 3'd4;

  localparam int SCORE_W    = 15;
  localparam int SCORE1_MSB = 31;
  localparam int DIRTY1     = 16;
  localparam int SCORE2_MSB = 15;
  localparam int DIRTY2     = 0;

  localparam int SCREEN_H = 480;
  localparam int BAR_H    = 80;

  function automatic logic [8:0] clamp_y(input logic [8:0] y, input logic [8:0] y_max);
    return (y > y_max) ? y_max : y;
  endfunction
endpackage

// File: rtl/pong_bar_arbiter.sv
// Two 1-deep bar request slots, clamped on write, granted round-robin onto the
// shared bar-update bus while vertical blanking is active.
module pong_bar_arbiter #(
  parameter logic [8:0] Y_MAX = 9'd400
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic       vblank_i,
  input  logic       load_i,
  input  logic [8:0] load_y_i,
  input  logic [1:0] req_valid_i,
  input  logic [8:0] req_y1_i,
  input  logic [8:0] req_y2_i,
  output logic       upd_valid_o,
  output logic       upd_sel_o,
  output logic [8:0] upd_y_o
);
  import pong_pkg::*;

  logic [1:0]      pend_q, pend_d;
  logic [1:0][8:0] slot_q, slot_d;
  logic            rr_q, rr_d;
  logic            grant, gsel;
  logic [1:0][8:0] req_y;

  assign req_y = {req_y2_i, req_y1_i};

  always_comb begin
    grant  = vblank_i && en_i && (|pend_q);
    // rr_q names the player that wins when both slots are pending
    gsel   = (pend_q == 2'b11) ? rr_q : pend_q[1];
    pend_d = pend_q;
    slot_d = slot_q;
    rr_d   = rr_q;
    if (grant) begin
      pend_d[gsel] = 1'b0;
      rr_d         = ~gsel;
    end
    if (load_i) begin
      pend_d = 2'b11;
      slot_d = {clamp_y(load_y_i, Y_MAX), clamp_y(load_y_i, Y_MAX)};
    end else if (en_i) begin
      for (int i = 0; i < 2; i++) begin
        if (req_valid_i[i]) begin
          slot_d[i] = clamp_y(req_y[i], Y_MAX);
          pend_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q      <= '0;
      slot_q      <= '0;
      rr_q        <= 1'b0;
      upd_valid_o <= 1'b0;
      upd_sel_o   <= 1'b0;
      upd_y_o     <= '0;
    end else begin
      pend_q      <= pend_d;
      slot_q      <= slot_d;
      rr_q        <= rr_d;
      upd_valid_o <= grant;
      if (grant) begin
        upd_sel_o <= gsel;
        upd_y_o   <= slot_q[gsel];
      end
    end
  end
endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: FSM, frame counter, scores with dirty flags and the
// packed status word; bar requests are forwarded to the arbiter.
module pong_game_ctrl #(
  parameter int SCREEN_H     = pong_pkg::SCREEN_H,
  parameter int BAR_H        = pong_pkg::BAR_H,
  parameter int Y_INIT       = 200,
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60
) (
  input  logic        CLK,
  input  logic        RST_BTN,
  input  logic        frame_end,
  input  logic        vblank,
  input  logic        start,
  input  logic [1:0]  req_valid,
  input  logic [8:0]  req_y1,
  input  logic [8:0]  req_y2,
  input  logic [1:0]  goal,
  input  logic        rd_strobe,
  output logic        upd_valid,
  output logic        upd_sel,
  output logic [8:0]  upd_y,
  output logic        enable_pong,
  output logic        ball_run,
  output logic        ball_reset,
  output logic [31:0] result,
  output logic [2:0]  state_o
);
  import pong_pkg::*;

  localparam logic [8:0]         Y_MAX   = 9'(SCREEN_H - BAR_H);
  localparam logic [SCORE_W-1:0] WIN     = SCORE_W'(WIN_SCORE);
  localparam logic [15:0]        FR_LAST = 16'(SERVE_FRAMES - 1);

  logic [2:0]         state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [SCORE_W-1:0] s1_q, s1_d, s2_q, s2_d;
  logic               d1_q, d1_d, d2_q, d2_d;
  logic               br_d, load;
  logic [31:0]        result_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    d1_d    = d1_q & ~rd_strobe;
    d2_d    = d2_q & ~rd_strobe;
    br_d    = 1'b0;
    load    = 1'b0;
    case (state_q)
      ST_MENU: if (start) begin
        s1_d = '0; s2_d = '0; d1_d = 1'b1; d2_d = 1'b1;
        load = 1'b1; br_d = 1'b1; cnt_d = '0;
        state_d = ST_SERVE;
      end
      ST_SERVE, ST_POINT: begin
        if (state_q == ST_POINT && (s1_q == WIN || s2_q == WIN)) state_d = ST_GAMEOVER;
        else if (frame_end) begin
          if (cnt_q == FR_LAST) state_d = ST_PLAY;
          else                  cnt_d   = cnt_q + 16'd1;
        end
      end
      ST_PLAY: if (goal == 2'b01 || goal == 2'b10) begin
        if (goal[0]) begin
          if (s1_q < WIN) s1_d = s1_q + 1'b1;
          d1_d = 1'b1;
        end else begin
          if (s2_q < WIN) s2_d = s2_q + 1'b1;
          d2_d = 1'b1;
        end
        cnt_d = '0; br_d = 1'b1;
        state_d = ST_POINT;
      end
      ST_GAMEOVER: if (start) state_d = ST_MENU;
      default: state_d = ST_MENU;
    endcase
  end

  always_comb begin
    result_d = '0;
    result_d[SCORE1_MSB -: SCORE_W] = s1_q;
    result_d[DIRTY1]                = d1_q;
    result_d[SCORE2_MSB -: SCORE_W] = s2_q;
    result_d[DIRTY2]                = d2_q;
  end

  // Outputs are registered from next state so they line up with state_o.
  always_ff @(posedge CLK or posedge RST_BTN) begin
    if (RST_BTN) begin
      state_q     <= ST_MENU;
      cnt_q       <= '0;
      s1_q        <= '0;
      s2_q        <= '0;
      d1_q        <= 1'b0;
      d2_q        <= 1'b0;
      enable_pong <= 1'b0;
      ball_run    <= 1'b0;
      ball_reset  <= 1'b0;
      result      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      d1_q        <= d1_d;
      d2_q        <= d2_d;
      enable_pong <= (state_d == ST_SERVE) || (state_d == ST_PLAY) || (state_d == ST_POINT);
      ball_run    <= (state_d == ST_PLAY);
      ball_reset  <= br_d;
      result      <= result_d;
    end
  end

  assign state_o = state_q;

  pong_bar_arbiter #(.Y_MAX(Y_MAX)) u_arb (
    .clk         (CLK),
    .rst         (RST_BTN),
    .en_i        (enable_pong),
    .vblank_i    (vblank),
    .load_i      (load),
    .load_y_i    (9'(Y_INIT)),
    .req_valid_i (req_valid),
    .req_y1_i    (req_y1),
    .req_y2_i    (req_y2),
    .upd_valid_o (upd_valid),
    .upd_sel_o   (upd_sel),
    .upd_y_o     (upd_y)
  );
endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl; bar updates are checked against a scoreboard queue.
module tb_pong_game_ctrl;
  logic        CLK = 1'b0, RST_BTN = 1'b0;
  logic        frame_end = 0, vblank = 0, start = 0, rd_strobe = 0;
  logic [1:0]  req_valid = 0, goal = 0;
  logic [8:0]  req_y1 = 0, req_y2 = 0;
  logic        upd_valid, upd_sel, enable_pong, ball_run, ball_reset;
  logic [8:0]  upd_y;
  logic [31:0] result;
  logic [2:0]  state_o;

  int total = 0, bad = 0, br_cnt = 0;
  logic [9:0] sb[$];

  pong_game_ctrl dut (
    .CLK(CLK), .RST_BTN(RST_BTN), .frame_end(frame_end), .vblank(vblank),
    .start(start), .req_valid(req_valid), .req_y1(req_y1), .req_y2(req_y2),
    .goal(goal), .rd_strobe(rd_strobe), .upd_valid(upd_valid), .upd_sel(upd_sel),
    .upd_y(upd_y), .enable_pong(enable_pong), .ball_run(ball_run),
    .ball_reset(ball_reset), .result(result), .state_o(state_o)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic pulse_start();
    start = 1; tick(); start = 0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_end = 1; tick(); frame_end = 0; tick();
    end
  endtask

  always @(negedge CLK) begin
    if (ball_reset === 1'b1) br_cnt++;
    if (upd_valid === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        assert (0) else begin
          bad++;
          $error("FAIL upd_unexpected observed=sel%0d/y%0d expected=none", upd_sel, upd_y);
        end
      end else begin
        chk("upd", {22'd0, upd_sel, upd_y}, {22'd0, sb.pop_front()});
      end
    end
  end

  initial begin
    #2 RST_BTN = 1;
    #1;
    chk("rst_state", state_o, 0);
    chk("rst_result", result, 0);
    chk("rst_outs", {upd_valid, upd_sel, upd_y, enable_pong, ball_run, ball_reset}, 0);
    tick(3);
    RST_BTN = 0;
    tick(2);

    // new game
    pulse_start();
    chk("start_state", state_o, 1);
    chk("start_ballrst", ball_reset, 1);
    chk("serve_enable", enable_pong, 1);
    tick();
    chk("start_result", result, 32'h0001_0001);
    sb.push_back({1'b0, 9'd200});
    sb.push_back({1'b1, 9'd200});
    frames(59);
    chk("serve_hold", state_o, 1);
    frames(1);
    chk("play_state", state_o, 2);
    chk("play_run", ball_run, 1);
    chk("br_cnt1", br_cnt, 1);
    vblank = 1; tick(4); vblank = 0;
    chk("init_upd_done", sb.size(), 0);

    // both players at once, player 2 clamped
    sb.push_back({1'b0, 9'd10});
    sb.push_back({1'b1, 9'd400});
    vblank = 1; req_valid = 2'b11; req_y1 = 10; req_y2 = 450;
    tick(); req_valid = 0;
    tick(4); vblank = 0;
    chk("dual_upd_done", sb.size(), 0);

    // latest request wins while blanking is low
    req_valid = 2'b01; req_y1 = 50; tick();
    req_y1 = 70; tick();
    req_valid = 0; tick(2);
    sb.push_back({1'b0, 9'd70});
    vblank = 1; tick(4); vblank = 0;
    chk("overwrite_done", sb.size(), 0);

    // scoring and dirty handling
    rd_strobe = 1; tick(); rd_strobe = 0; tick();
    chk("rd_clear", result, 0);
    goal = 2'b01; tick(); goal = 0;
    chk("goal_state", state_o, 3);
    chk("goal_ballrst", ball_reset, 1);
    chk("point_run", ball_run, 0);
    tick();
    chk("goal_result", result, 32'h0003_0000);
    rd_strobe = 1; tick(); rd_strobe = 0; tick();
    chk("rd_dirty1", result, 32'h0002_0000);
    frames(60);
    chk("point_play", state_o, 2);
    goal = 2'b11; tick(); goal = 0; tick();
    chk("goal11_state", state_o, 2);
    chk("goal11_result", result, 32'h0002_0000);

    // player 2 wins
    for (int i = 0; i < 7; i++) begin
      goal = 2'b10; tick(); goal = 0;
      if (i < 6) frames(60);
    end
    tick();
    chk("gameover_state", state_o, 4);
    chk("gameover_en", {enable_pong, ball_run}, 0);
    chk("gameover_result", result, 32'h0002_000F);
    chk("br_cnt9", br_cnt, 9);
    vblank = 1; req_valid = 2'b11; req_y1 = 33; req_y2 = 44;
    tick(); req_valid = 0; tick(4); vblank = 0;
    chk("gameover_nodrop", sb.size(), 0);

    pulse_start();
    chk("menu_state", state_o, 0);
    chk("menu_result", result, 32'h0002_000F);
    pulse_start();
    chk("new_serve", state_o, 1);
    tick();
    chk("new_result", result, 32'h0001_0001);
    chk("br_cnt10", br_cnt, 10);

    // reset mid-serve with pending slots
    req_valid = 2'b01; req_y1 = 123; tick(); req_valid = 0;
    #3 RST_BTN = 1;
    #1;
    chk("arst_outs", {upd_valid, upd_sel, upd_y, enable_pong, ball_run, ball_reset}, 0);
    chk("arst_result", result, 0);
    chk("arst_state", state_o, 0);
    sb.delete();
    vblank = 1;
    tick(2);
    RST_BTN = 0;
    tick(6);
    vblank = 0;
    chk("post_rst_state", state_o, 0);
    chk("post_rst_sb", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Central sequencer for the Pong datapath. It runs the game state machine (menu, serve, play, point, game over) and keeps both scores. It also arbitrates bar-position requests from the two players onto the single shared bar-update bus that drives the two bar renderers, and exposes the packed score/status word returned to the processor's custom instruction. It sits between the custom-instruction decode and the printBar/printBall/printMenu renderers.

Parameters:
SCREEN_H, 480, visible lines
BAR_H, 80, bar height in lines; bar y is clamped to [0, SCREEN_H-BAR_H]
Y_INIT, 200, bar y loaded at new game
WIN_SCORE, 7, score that ends the game (1..32767)
SERVE_FRAMES, 60, frame_end pulses spent in POINT/SERVE before play resumes (>=1)

Ports:
CLK  in  1  system clock
RST_BTN  in  1  reset, asynchronous, active-high
frame_end  in  1  one-cycle pulse at start of vertical blank
vblank  in  1  high during vertical blanking; bar updates are issued only while high
start  in  1  one-cycle start/confirm pulse (custom-instruction bit 11)
req_valid  in  2  per-player request pulse; bit0 = player 1, bit1 = player 2
req_y1  in  9  requested absolute y, player 1
req_y2  in  9  requested absolute y, player 2
goal  in  2  one-cycle goal pulses from ball logic; bit0 = player 1 scored, bit1 = player 2 scored
rd_strobe  in  1  one-cycle pulse when the status word is read
upd_valid  out  1  bar-update pulse
upd_sel  out  1  0 = bar 1, 1 = bar 2
upd_y  out  9  clamped y for the selected bar
enable_pong  out  1  game active (renderers show the field, not the menu)
ball_run  out  1  ball may move
ball_reset  out  1  one-cycle pulse that recentres the ball
result  out  32  [31:17] score1, [16] dirty1, [15:1] score2, [0] dirty2
state_o  out  3  current FSM state, for debug

Behaviour:
- Reset (async, RST_BTN=1): state MENU, scores 0, dirty bits 0, pending flags 0, round-robin pointer to player 1.
- Reset values of outputs: upd_valid=0, upd_sel=0, upd_y=0, enable_pong=0, ball_run=0, ball_reset=0, result=0, state_o=MENU.
- All outputs are registered.
- State encoding: MENU=0, SERVE=1, PLAY=2, POINT=3, GAMEOVER=4; it lives in the package.
- MENU:
  - On start: clear both scores, set both dirty bits, load both pending slots with Y_INIT, pulse ball_reset, go to SERVE.
- SERVE:
  - Count SERVE_FRAMES frame_end pulses, then go to PLAY.
  - start is ignored.
- PLAY:
  - ball_run=1.
  - goal=01: score1+1 and dirty1 set; goal=10: score2+1 and dirty2 set.
  - Any single goal goes to POINT and pulses ball_reset on the transition cycle.
  - goal=11 is ignored: no score change, stay in PLAY.
- POINT:
  - If either score equals WIN_SCORE, go to GAMEOVER on the next cycle.
  - Otherwise count SERVE_FRAMES frame_end pulses, then go to PLAY.
- GAMEOVER:
  - Scores hold.
  - start goes to MENU (the next start then begins a new game).
- enable_pong is 1 in SERVE, PLAY and POINT. ball_run is 1 only in PLAY.
- Frame counter:
  - Cleared on entry to SERVE and POINT.
  - A frame_end coinciding with the entry cycle is not counted.
- Requests:
  - Accepted only when enable_pong=1; dropped in MENU and GAMEOVER.
  - req_valid[i] writes slot i = clamp(req_y_i) and sets pending[i] on the next cycle.
  - A new request overwrites an unsent one (latest wins).
  - Clamp rule: a value above SCREEN_H-BAR_H becomes SCREEN_H-BAR_H.
- Arbitration:
  - While vblank=1, at most one grant per cycle.
  - Only one slot pending: grant it.
  - Both pending: grant the player opposite the round-robin pointer's last grant; the pointer updates on every grant.
  - Grant cycle: upd_valid=1 with upd_sel/upd_y, and that pending bit clears.
  - A request arriving in the same cycle as its own grant re-sets pending with the new value, so no update is lost.
  - Minimum latency from req_valid to upd_valid is 2 cycles when vblank is already high.
- Scores are 15-bit and saturate at WIN_SCORE.
- Dirty bits: set on every score change or clear, cleared by rd_strobe. If set and rd_strobe occur in the same cycle, set wins.
- result is updated one cycle after a score or dirty change.
- Reset asserted mid-operation aborts immediately: pending updates are discarded and no upd_valid follows.

Decomposition:
- Package pong_pkg:
  - state enum
  - result bit-field positions (SCORE1_MSB=31, DIRTY1=16, SCORE2_MSB=15, DIRTY2=0)
  - screen constants SCREEN_H, BAR_H
- Sub-module pong_bar_arbiter:
  - two 1-deep pending slots, clamp, round-robin grant onto the upd_* bus
  - gated by vblank and enable_pong
- The top level holds the FSM, frame counter, scores and dirty bits.

Test Plan:
- Reset, then start, then 60 frame_end pulses → ball_reset once; state goes MENU→SERVE→PLAY; result=0x00010001; first vblank issues upd sel0 y200, then sel1 y200.
- PLAY: req_valid=11 with y1=10 and y2=450 while vblank=1 → two consecutive upd_valid: sel0 y10, then sel1 y400 (clamped).
- Two req_valid[0] pulses (y=50, y=70) while vblank=0, then vblank → exactly one upd: sel0 y70.
- PLAY: goal=01 → score1=1, dirty1=1, state POINT, ball_reset pulse; rd_strobe → result[16]=0; goal=11 in PLAY → no change.
- Drive score2 to WIN_SCORE → GAMEOVER, enable_pong=0, ball_run=0; req_valid is ignored; start → MENU, then start → scores 0.
- Assert RST_BTN mid-SERVE with pending requests → all outputs 0 asynchronously; no upd_valid after release.
